// File: rtl/vga_apb4_mst_pkg.sv
// Shared types for the APB4 initiator: FSM state encoding and the
// request/response records used by the command and completion streams.
package vga_apb4_mst_pkg;

  localparam int APB_PROT_W  = 3;
  localparam int REQ_ADDR_W  = 32;
  localparam int REQ_DATA_W  = 32;
  localparam int REQ_STRB_W  = REQ_DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_mst_state_e;

  typedef struct packed {
    logic                  write;
    logic [REQ_ADDR_W-1:0] addr;
    logic [REQ_DATA_W-1:0] wdata;
    logic [REQ_STRB_W-1:0] strb;
    logic [APB_PROT_W-1:0] prot;
  } apb_req_t;

  typedef struct packed {
    logic [REQ_DATA_W-1:0] rdata;
    logic                  err;
  } apb_rsp_t;

endpackage

// File: rtl/vga_apb4_mst_if.sv
// Command/response streams plus the APB4 bus of the initiator, bundled so
// the requester, the initiator and the slave side share one connection.
interface vga_apb4_mst_if
  import vga_apb4_mst_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  logic                  req_valid_i;
  logic                  req_ready_o;
  logic                  req_write_i;
  logic [ADDR_WIDTH-1:0] req_addr_i;
  logic [DATA_WIDTH-1:0] req_wdata_i;
  logic [STRB_WIDTH-1:0] req_strb_i;
  logic [APB_PROT_W-1:0] req_prot_i;

  logic                  rsp_valid_o;
  logic                  rsp_ready_i;
  logic [DATA_WIDTH-1:0] rsp_rdata_o;
  logic                  rsp_err_o;

  logic [ADDR_WIDTH-1:0] paddr_o;
  logic [APB_PROT_W-1:0] pprot_o;
  logic                  psel_o;
  logic                  penable_o;
  logic                  pwrite_o;
  logic [DATA_WIDTH-1:0] pwdata_o;
  logic [STRB_WIDTH-1:0] pstrb_o;
  logic                  pready_i;
  logic [DATA_WIDTH-1:0] prdata_i;
  logic                  pslverr_i;

  modport master (
    input  req_valid_i, req_write_i, req_addr_i, req_wdata_i, req_strb_i, req_prot_i,
    output req_ready_o,
    output rsp_valid_o, rsp_rdata_o, rsp_err_o,
    input  rsp_ready_i,
    output paddr_o, pprot_o, psel_o, penable_o, pwrite_o, pwdata_o, pstrb_o,
    input  pready_i, prdata_i, pslverr_i
  );

  modport slave (
    output req_valid_i, req_write_i, req_addr_i, req_wdata_i, req_strb_i, req_prot_i,
    input  req_ready_o,
    input  rsp_valid_o, rsp_rdata_o, rsp_err_o,
    output rsp_ready_i,
    input  paddr_o, pprot_o, psel_o, penable_o, pwrite_o, pwdata_o, pstrb_o,
    output pready_i, prdata_i, pslverr_i
  );

endinterface

// File: rtl/vga_apb4_mst_wdog.sv
// pready watchdog: counts ACCESS cycles without pready and flags expiry on the
// TIMEOUT_CYC-th one; TIMEOUT_CYC == 0 disables it entirely.
module vga_apb4_mst_wdog #(
  parameter int TIMEOUT_CYC = 256
) (
  input  logic pclk,
  input  logic presetn,
  input  logic clr,
  input  logic run,
  input  logic pready,
  output logic expire
);

  generate
    if (TIMEOUT_CYC == 0) begin : g_off
      logic unused_wdog_inputs;
      assign unused_wdog_inputs = ^{pclk, presetn, clr, run, pready};
      assign expire = 1'b0;
    end else begin : g_on
      localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
      localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
      localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYC);

      logic [CNT_W-1:0] cnt;

      // Saturating so a stuck run can never wrap back into a false expiry.
      always_ff @(posedge pclk) begin
        if (!presetn || clr) begin
          cnt <= '0;
        end else if (run && !pready && (cnt != CNT_MAX)) begin
          cnt <= cnt + CNT_W'(1);
        end
      end

      assign expire = run && !pready && (cnt == CNT_LAST);
    end
  endgenerate

endmodule

// File: rtl/vga_apb4_mst.sv
// APB4 initiator: one valid/ready command becomes one APB transfer, whose
// completion (or watchdog timeout) is returned on the response stream.
module vga_apb4_mst
  import vga_apb4_mst_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic          pclk,
  input  logic          presetn,
  vga_apb4_mst_if.master bus
);

  localparam int STRB_W = DATA_WIDTH / 8;

  typedef struct packed {
    logic                  write;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_W-1:0]     strb;
    logic [APB_PROT_W-1:0] prot;
  } req_t;

  apb_mst_state_e        state;
  req_t                  req_q;
  logic                  req_ready_q;
  logic                  psel_q;
  logic                  penable_q;
  logic                  rsp_valid_q;
  logic                  rsp_err_q;
  logic [DATA_WIDTH-1:0] rsp_rdata_q;
  logic                  wd_expire;

  vga_apb4_mst_wdog #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_wdog (
    .pclk    (pclk),
    .presetn (presetn),
    .clr     (state == SETUP),
    .run     (state == ACCESS),
    .pready  (bus.pready_i),
    .expire  (wd_expire)
  );

  always_ff @(posedge pclk) begin
    if (!presetn) begin
      state       <= IDLE;
      req_ready_q <= 1'b1;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      req_q       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid_i) begin
            req_q.write <= bus.req_write_i;
            req_q.addr  <= bus.req_addr_i;
            req_q.wdata <= bus.req_wdata_i;
            // Reads carry no byte lanes on APB4.
            req_q.strb  <= bus.req_write_i ? bus.req_strb_i : '0;
            req_q.prot  <= bus.req_prot_i;
            req_ready_q <= 1'b0;
            psel_q      <= 1'b1;
            state       <= SETUP;
          end
        end
        SETUP: begin
          penable_q <= 1'b1;
          state     <= ACCESS;
        end
        ACCESS: begin
          // pready on the expiry cycle is a genuine completion, so it wins.
          if (bus.pready_i || wd_expire) begin
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= bus.pready_i ? bus.pslverr_i : 1'b1;
            rsp_rdata_q <= (bus.pready_i && !req_q.write) ? bus.prdata_i : '0;
            state       <= RESP;
          end
        end
        RESP: begin
          if (bus.rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready_o = req_ready_q;
  assign bus.rsp_valid_o = rsp_valid_q;
  assign bus.rsp_rdata_o = rsp_rdata_q;
  assign bus.rsp_err_o   = rsp_err_q;
  assign bus.paddr_o     = req_q.addr;
  assign bus.pprot_o     = req_q.prot;
  assign bus.psel_o      = psel_q;
  assign bus.penable_o   = penable_q;
  assign bus.pwrite_o    = req_q.write;
  assign bus.pwdata_o    = req_q.wdata;
  assign bus.pstrb_o     = req_q.strb;

endmodule
